ddr2_backend_fifos_param: RTL and testbench

DDR2_BACKEND_FIFOS_PARAM -- requirements
Module: ddr2_backend_fifos_param

---
 rtl/ddr2_backend_fifos_param.sv | 202 ++++++++++++++++++++
 tb/tb_ddr2_backend_fifos_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_backend_fifos_param.sv
// DDR2 back-end address and write-data FIFOs (first-word-fall-through) with an
// optional write-data training pattern generator, enabled by BACKEND_TRAIN_PATTERN_EN.
module ddr2_backend_fifos_param #(
   parameter int DQ_WIDTH  = 64,
   parameter int DM_WIDTH  = 8,
   parameter int AF_DEPTH  = 16,
   parameter int WDF_DEPTH = 16,
   parameter int AF_MARGIN = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                  clk0,
   input  logic                  rst,
   input  logic [35:0]           app_af_addr,
   input  logic                  app_af_wren,
   input  logic                  ctrl_af_rden,
   output logic [35:0]           af_addr,
   output logic                  af_empty,
   output logic                  af_almost_full,
   input  logic [2*DQ_WIDTH-1:0] app_wdf_data,
   input  logic [2*DM_WIDTH-1:0] app_mask_data,
   input  logic                  app_wdf_wren,
   input  logic                  ctrl_wdf_rden,
   output logic [2*DQ_WIDTH-1:0] wdf_data,
   output logic [2*DM_WIDTH-1:0] mask_data,
   output logic                  wdf_empty,
   output logic                  wdf_almost_full,
   output logic                  pattern_done,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam int AAW = $clog2(AF_DEPTH);
   localparam int WAW = $clog2(WDF_DEPTH);
   localparam int DW  = 2*DQ_WIDTH;
   localparam int MW  = 2*DM_WIDTH;

   localparam logic [AAW:0] AF_FULL  = (AAW+1)'(AF_DEPTH);
   localparam logic [AAW:0] AF_THR   = (AAW+1)'(AF_DEPTH - AF_MARGIN);
   localparam logic [WAW:0] WDF_FULL = (WAW+1)'(WDF_DEPTH);
   localparam logic [WAW:0] WDF_THR  = (WAW+1)'(WDF_DEPTH - AF_MARGIN);

   logic [35:0]      af_mem [AF_DEPTH];
   logic [AAW-1:0]   af_wp, af_rp;
   logic [AAW:0]     af_cnt, af_cnt_nxt;
   logic             af_full, af_push, af_pop;

   logic [DW+MW-1:0] wdf_mem [WDF_DEPTH];
   logic [WAW-1:0]   wdf_wp, wdf_rp;
   logic [WAW:0]     wdf_cnt, wdf_cnt_nxt;
   logic             wdf_full, wdf_push, wdf_pop;

   logic             wdf_req;
   logic [DW-1:0]    wdf_din;
   logic [MW-1:0]    wdf_min;
   logic             ovf_hit, unf_hit;

   // Address FIFO: a pop frees a slot, so a push to a full FIFO with a pop is kept
   assign af_empty = (af_cnt == '0);
   assign af_full  = (af_cnt == AF_FULL);
   assign af_pop   = ctrl_af_rden && !af_empty;
   assign af_push  = app_af_wren && (!af_full || af_pop);
   assign af_addr  = af_mem[af_rp];

   always_comb begin
      af_cnt_nxt = af_cnt;
      if (af_push && !af_pop)
         af_cnt_nxt = af_cnt + (AAW+1)'(1);
      else if (af_pop && !af_push)
         af_cnt_nxt = af_cnt - (AAW+1)'(1);
   end

   assign wdf_empty = (wdf_cnt == '0);
   assign wdf_full  = (wdf_cnt == WDF_FULL);
   assign wdf_pop   = ctrl_wdf_rden && !wdf_empty;
   assign wdf_push  = wdf_req && (!wdf_full || wdf_pop);
   assign {wdf_data, mask_data} = wdf_mem[wdf_rp];

   always_comb begin
      wdf_cnt_nxt = wdf_cnt;
      if (wdf_push && !wdf_pop)
         wdf_cnt_nxt = wdf_cnt + (WAW+1)'(1);
      else if (wdf_pop && !wdf_push)
         wdf_cnt_nxt = wdf_cnt - (WAW+1)'(1);
   end

   assign ovf_hit = (app_af_wren && af_full && !af_pop) ||
                    (wdf_req && wdf_full && !wdf_pop);
   assign unf_hit = (ctrl_af_rden && af_empty) ||
                    (ctrl_wdf_rden && wdf_empty);

`ifdef BACKEND_TRAIN_PATTERN_EN
   typedef enum logic [1:0] {
      P_IDLE,
      P_WRITE,
      P_DONE
   } pat_state_t;

   localparam logic [2:0] PAT_HALF = 3'(BURST_LEN / 2);
   localparam logic [2:0] PAT_LAST = 3'(BURST_LEN - 1);

   pat_state_t          p_state, p_state_nxt;
   logic [2:0]          p_idx, p_idx_nxt;
   logic                pat_push;
   logic [3:0]          nib_h, nib_l;
   logic [DQ_WIDTH-1:0] pat_h, pat_l;

   always_ff @(posedge clk0) begin
      if (rst) begin
         p_state <= P_IDLE;
         p_idx   <= '0;
      end else begin
         p_state <= p_state_nxt;
         p_idx   <= p_idx_nxt;
      end
   end

   always_comb begin
      p_state_nxt = p_state;
      p_idx_nxt   = p_idx;
      pat_push    = 1'b0;
      unique case (p_state)
         P_IDLE:  p_state_nxt = P_WRITE;
         P_WRITE: begin
            pat_push  = 1'b1;
            p_idx_nxt = p_idx + 3'd1;
            if (p_idx == PAT_LAST)
               p_state_nxt = P_DONE;
         end
         P_DONE:  p_state_nxt = P_DONE;
         default: p_state_nxt = P_IDLE;
      endcase
   end

   // First half of the burst is F/0, the rest alternates A/5 and 5/A
   always_comb begin
      nib_h = 4'hF;
      nib_l = 4'h0;
      if (p_idx >= PAT_HALF) begin
         nib_h = p_idx[0] ? 4'h5 : 4'hA;
         nib_l = p_idx[0] ? 4'hA : 4'h5;
      end
      for (int b = 0; b < DQ_WIDTH; b++) begin
         pat_h[b] = nib_h[2'(b)];
         pat_l[b] = nib_l[2'(b)];
      end
   end

   assign pattern_done = (p_state == P_DONE);
   assign wdf_req      = pattern_done ? app_wdf_wren  : pat_push;
   assign wdf_din      = pattern_done ? app_wdf_data  : {pat_h, pat_l};
   assign wdf_min      = pattern_done ? app_mask_data : '0;
`else
   // Burst length only shapes the generator, which is absent in this build
   logic unused_burst_len;
   assign unused_burst_len = (BURST_LEN != 0);

   assign pattern_done = 1'b1;
   assign wdf_req      = app_wdf_wren;
   assign wdf_din      = app_wdf_data;
   assign wdf_min      = app_mask_data;
`endif

   always_ff @(posedge clk0) begin
      if (rst) begin
         af_wp           <= '0;
         af_rp           <= '0;
         af_cnt          <= '0;
         af_almost_full  <= 1'b0;
         wdf_wp          <= '0;
         wdf_rp          <= '0;
         wdf_cnt         <= '0;
         wdf_almost_full <= 1'b0;
         err_overflow    <= 1'b0;
         err_underflow   <= 1'b0;
      end else begin
         if (af_push)
            af_wp <= af_wp + AAW'(1);
         if (af_pop)
            af_rp <= af_rp + AAW'(1);
         af_cnt         <= af_cnt_nxt;
         af_almost_full <= (af_cnt_nxt >= AF_THR);
         if (wdf_push)
            wdf_wp <= wdf_wp + WAW'(1);
         if (wdf_pop)
            wdf_rp <= wdf_rp + WAW'(1);
         wdf_cnt         <= wdf_cnt_nxt;
         wdf_almost_full <= (wdf_cnt_nxt >= WDF_THR);
         if (ovf_hit)
            err_overflow <= 1'b1;
         if (unf_hit)
            err_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk0) begin
      if (af_push)
         af_mem[af_wp] <= app_af_addr;
      if (wdf_push)
         wdf_mem[wdf_wp] <= {wdf_din, wdf_min};
   end

endmodule

// File: tb/tb_ddr2_backend_fifos_param.sv
// Randomized and directed bench for ddr2_backend_fifos_param against a
// queue-based model; builds with or without BACKEND_TRAIN_PATTERN_EN.
module tb_ddr2_backend_fifos_param;

   localparam int DQ   = 16;
   localparam int DM   = 2;
   localparam int AFD  = 16;
   localparam int WDFD = 16;
   localparam int MARG = 4;
   localparam int BL   = 8;
   localparam int W    = 2*DQ;
   localparam int M    = 2*DM;

   logic          clk0 = 1'b0;
   logic          rst;
   logic [35:0]   app_af_addr;
   logic          app_af_wren;
   logic          ctrl_af_rden;
   logic [35:0]   af_addr;
   logic          af_empty;
   logic          af_almost_full;
   logic [W-1:0]  app_wdf_data;
   logic [M-1:0]  app_mask_data;
   logic          app_wdf_wren;
   logic          ctrl_wdf_rden;
   logic [W-1:0]  wdf_data;
   logic [M-1:0]  mask_data;
   logic          wdf_empty;
   logic          wdf_almost_full;
   logic          pattern_done;
   logic          err_overflow;
   logic          err_underflow;

   always #5 clk0 = ~clk0;

   ddr2_backend_fifos_param #(
      .DQ_WIDTH (DQ),
      .DM_WIDTH (DM),
      .AF_DEPTH (AFD),
      .WDF_DEPTH(WDFD),
      .AF_MARGIN(MARG),
      .BURST_LEN(BL)
   ) dut (
      .clk0           (clk0),
      .rst            (rst),
      .app_af_addr    (app_af_addr),
      .app_af_wren    (app_af_wren),
      .ctrl_af_rden   (ctrl_af_rden),
      .af_addr        (af_addr),
      .af_empty       (af_empty),
      .af_almost_full (af_almost_full),
      .app_wdf_data   (app_wdf_data),
      .app_mask_data  (app_mask_data),
      .app_wdf_wren   (app_wdf_wren),
      .ctrl_wdf_rden  (ctrl_wdf_rden),
      .wdf_data       (wdf_data),
      .mask_data      (mask_data),
      .wdf_empty      (wdf_empty),
      .wdf_almost_full(wdf_almost_full),
      .pattern_done   (pattern_done),
      .err_overflow   (err_overflow),
      .err_underflow  (err_underflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [35:0]    m_af[$];
   logic [W+M-1:0] m_wdf[$];
   bit             m_ovf, m_unf, m_afaf, m_wdfaf;
   int             m_pcyc;

`ifdef BACKEND_TRAIN_PATTERN_EN
   bit [3:0] ph8[8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'h5, 4'hA, 4'h5};
   bit [3:0] pl8[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'hA, 4'h5, 4'hA};
   bit [3:0] ph4[4] = '{4'hF, 4'hF, 4'hA, 4'h5};
   bit [3:0] pl4[4] = '{4'h0, 4'h0, 4'h5, 4'hA};
   logic [31:0] exp8[8] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
                            32'hFFFF0000, 32'hAAAA5555, 32'h5555AAAA,
                            32'hAAAA5555, 32'h5555AAAA};

   function automatic logic [W+M-1:0] pat_word(int i);
      bit [3:0] h, l;
      h = (BL == 8) ? ph8[i] : ph4[i];
      l = (BL == 8) ? pl8[i] : pl4[i];
      return {{(DQ/4){h}}, {(DQ/4){l}}, {M{1'b0}}};
   endfunction
`endif

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit             pop_ok, push_ok, req;
      logic [W+M-1:0] word;
      if (rst) begin
         m_af.delete();
         m_wdf.delete();
         m_ovf   = 0;
         m_unf   = 0;
         m_afaf  = 0;
         m_wdfaf = 0;
         m_pcyc  = 0;
         return;
      end
      pop_ok  = ctrl_af_rden && m_af.size() > 0;
      push_ok = app_af_wren && (m_af.size() < AFD || pop_ok);
      if (ctrl_af_rden && m_af.size() == 0) m_unf = 1;
      if (app_af_wren && !push_ok) m_ovf = 1;
      if (pop_ok) void'(m_af.pop_front());
      if (push_ok) m_af.push_back(app_af_addr);
      m_afaf = m_af.size() >= AFD - MARG;

      req  = app_wdf_wren;
      word = {app_wdf_data, app_mask_data};
`ifdef BACKEND_TRAIN_PATTERN_EN
      if (m_pcyc <= BL) begin
         req = (m_pcyc >= 1);
         if (req) word = pat_word(m_pcyc - 1);
         m_pcyc++;
      end
`endif
      pop_ok  = ctrl_wdf_rden && m_wdf.size() > 0;
      push_ok = req && (m_wdf.size() < WDFD || pop_ok);
      if (ctrl_wdf_rden && m_wdf.size() == 0) m_unf = 1;
      if (req && !push_ok) m_ovf = 1;
      if (pop_ok) void'(m_wdf.pop_front());
      if (push_ok) m_wdf.push_back(word);
      m_wdfaf = m_wdf.size() >= WDFD - MARG;
   endtask

   task automatic check_all();
      chk("af_empty", af_empty, m_af.size() == 0);
      if (m_af.size() > 0) chk("af_addr", af_addr, m_af[0]);
      chk("af_almost_full", af_almost_full, m_afaf);
      chk("wdf_empty", wdf_empty, m_wdf.size() == 0);
      if (m_wdf.size() > 0) begin
         chk("wdf_data", wdf_data, m_wdf[0][W+M-1:M]);
         chk("mask_data", mask_data, m_wdf[0][M-1:0]);
      end
      chk("wdf_almost_full", wdf_almost_full, m_wdfaf);
`ifdef BACKEND_TRAIN_PATTERN_EN
      chk("pattern_done", pattern_done, m_pcyc > BL);
`else
      chk("pattern_done", pattern_done, 1);
`endif
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_underflow", err_underflow, m_unf);
   endtask

   task automatic step();
      @(posedge clk0);
      model_edge();
      @(negedge clk0);
      check_all();
   endtask

   task automatic clr_in();
      app_af_addr   = '0;
      app_af_wren   = 0;
      ctrl_af_rden  = 0;
      app_wdf_data  = '0;
      app_mask_data = '0;
      app_wdf_wren  = 0;
      ctrl_wdf_rden = 0;
   endtask

   initial begin
      clr_in();
      rst = 1;
      step();
      step();
      chk("rst_af_empty", af_empty, 1);
      chk("rst_wdf_empty", wdf_empty, 1);
      chk("rst_af_af", af_almost_full, 0);
      chk("rst_wdf_af", wdf_almost_full, 0);
      chk("rst_ovf", err_overflow, 0);
      chk("rst_unf", err_underflow, 0);
      rst = 0;

`ifdef BACKEND_TRAIN_PATTERN_EN
      chk("rst_pattern_done", pattern_done, 0);
      app_wdf_wren = 1;
      app_wdf_data = 32'hDEADBEEF;
      for (int c = 1; c <= 9; c++) begin
         if (c == 5) app_wdf_wren = 0;
         step();
         if (c == 8) chk("pd_cycle9", pattern_done, 0);
      end
      chk("pd_cycle10", pattern_done, 1);
      chk("pat_no_ovf", err_overflow, 0);
      for (int i = 0; i < 8; i++) begin
         chk("pat_word", wdf_data, exp8[i]);
         chk("pat_mask", mask_data, 0);
         ctrl_wdf_rden = 1;
         step();
         ctrl_wdf_rden = 0;
      end
      chk("pat_drained", wdf_empty, 1);
`else
      chk("rst_pattern_done", pattern_done, 1);
`endif

      for (int i = 1; i <= 16; i++) begin
         app_af_addr = 36'h100 + 36'(i);
         app_af_wren = 1;
         step();
         if (i == 11) chk("af_af_push11", af_almost_full, 0);
         if (i == 12) chk("af_af_push12", af_almost_full, 1);
      end
      chk("ovf_before17", err_overflow, 0);
      app_af_addr = 36'h200;
      step();
      chk("ovf_push17", err_overflow, 1);
      chk("af_head_push1", af_addr, 36'h101);
      app_af_addr  = 36'hABC;
      ctrl_af_rden = 1;
      step();
      app_af_wren = 0;
      chk("full_pushpop_af", af_almost_full, 1);
      for (int k = 2; k <= 16; k++) begin
         chk("af_order", af_addr, 36'h100 + 36'(k));
         step();
      end
      chk("af_abc_16th", af_addr, 36'hABC);
      step();
      ctrl_af_rden = 0;
      chk("af_drained", af_empty, 1);

      chk("unf_before", err_underflow, 0);
      ctrl_wdf_rden = 1;
      step();
      ctrl_wdf_rden = 0;
      chk("unf_set", err_underflow, 1);
      chk("unf_wdf_empty", wdf_empty, 1);
      step();
      chk("unf_sticky", err_underflow, 1);

      for (int i = 0; i < 5; i++) begin
         app_af_addr  = 36'h300 + 36'(i);
         app_af_wren  = 1;
         app_wdf_data = $urandom();
         app_wdf_wren = 1;
         step();
      end
      clr_in();
      rst = 1;
      step();
      rst = 0;
      chk("rst2_af_empty", af_empty, 1);
      chk("rst2_wdf_empty", wdf_empty, 1);
      chk("rst2_af_af", af_almost_full, 0);
      chk("rst2_ovf", err_overflow, 0);
      chk("rst2_unf", err_underflow, 0);
      app_af_addr   = 36'h5A5;
      app_af_wren   = 1;
      app_wdf_data  = 32'h12345678;
      app_mask_data = 4'h9;
      app_wdf_wren  = 1;
      step();
      clr_in();
      chk("rst2_af_head", af_addr, 36'h5A5);
      chk("rst2_af_nonempty", af_empty, 0);
`ifdef BACKEND_TRAIN_PATTERN_EN
      chk("rst2_pd", pattern_done, 0);
`else
      chk("rst2_wdf_head", wdf_data, 32'h12345678);
      chk("rst2_mask_head", mask_data, 4'h9);
`endif

      for (int ph = 0; ph < 8; ph++) begin
         int pw;
         pw = (ph % 2 == 0) ? 75 : 25;
         for (int k = 0; k < 400; k++) begin
            rst           = ($urandom_range(0, 299) == 0);
            app_af_addr   = 36'({$urandom(), $urandom()});
            app_af_wren   = ($urandom_range(0, 99) < pw);
            ctrl_af_rden  = ($urandom_range(0, 99) < 100 - pw);
            app_wdf_data  = $urandom();
            app_mask_data = 4'($urandom());
            app_wdf_wren  = ($urandom_range(0, 99) < pw);
            ctrl_wdf_rden = ($urandom_range(0, 99) < 100 - pw);
            step();
         end
      end
      rst = 0;
      clr_in();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
